// File: rtl/canvas_write_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | canvas_write_sequencer_if                                            |
// | Pen/clear request handshake and canvas write-port bundle.            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface canvas_write_sequencer_if;
  logic        pen_req;
  logic [6:0]  pen_x;
  logic [5:0]  pen_y;
  logic [15:0] pen_colour;
  logic        brush_big;
  logic        pen_ack;
  logic        clear_req;
  logic        clear_done;
  logic        busy;
  logic        wr_en;
  logic [12:0] wr_addr;
  logic [15:0] wr_data;

  modport master (
    output pen_req, pen_x, pen_y, pen_colour, brush_big, clear_req,
    input  pen_ack, clear_done, busy, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  pen_req, pen_x, pen_y, pen_colour, brush_big, clear_req,
    output pen_ack, clear_done, busy, wr_en, wr_addr, wr_data
  );
endinterface
`default_nettype wire

// File: rtl/canvas_write_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | canvas_write_sequencer                                               |
// | Arbitrates the canvas write port between pen stamps and full clears. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module canvas_write_sequencer #(
  parameter int          WIDTH        = 96,
  parameter int          HEIGHT       = 64,
  parameter logic [15:0] CLEAR_COLOUR = 16'h0000
) (
  input  logic                     CLOCK,
  input  logic                     reset,
  canvas_write_sequencer_if.slave  bus
);

  localparam logic [1:0]  c_idle      = 2'd0;
  localparam logic [1:0]  c_stamp     = 2'd1;
  localparam logic [1:0]  c_clear     = 2'd2;
  localparam logic [7:0]  c_width8    = 8'(WIDTH);
  localparam logic [7:0]  c_height8   = 8'(HEIGHT);
  localparam logic [12:0] c_width13   = 13'(WIDTH);
  localparam logic [12:0] c_last_addr = 13'(WIDTH * HEIGHT - 1);

  logic [1:0]  state_q,         state_d;
  logic        clear_pending_q, clear_pending_d;
  logic [6:0]  cx_q,            cx_d;
  logic [5:0]  cy_q,            cy_d;
  logic [15:0] colour_q,        colour_d;
  logic        big_q,           big_d;
  logic [1:0]  sx_q,            sx_d;
  logic [1:0]  sy_q,            sy_d;
  logic [12:0] clr_addr_q,      clr_addr_d;
  logic        last_clear_q,    last_clear_d;
  logic        pen_ack_q,       pen_ack_d;
  logic        clear_done_q,    clear_done_d;
  logic        busy_q,          busy_d;
  logic        wr_en_q,         wr_en_d;
  logic [12:0] wr_addr_q,       wr_addr_d;
  logic [15:0] wr_data_q,       wr_data_d;

  logic signed [7:0] w_px;
  logic signed [7:0] w_py;
  logic              w_in_range;
  logic [12:0]       w_addr;
  logic              w_last_step;

  // Stamp point = centre + (s - 1); a 1x1 stamp parks sx/sy at 1 so the offset is zero.
  always_comb begin
    w_px        = $signed({1'b0, cx_q}) + $signed({6'b0, sx_q}) - 8'sd1;
    w_py        = $signed({2'b0, cy_q}) + $signed({6'b0, sy_q}) - 8'sd1;
    w_in_range  = !w_px[7] && !w_py[7] &&
                  ($unsigned(w_px) < c_width8) && ($unsigned(w_py) < c_height8);
    w_addr      = {7'b0, w_py[5:0]} * c_width13 + {6'b0, w_px[6:0]};
    w_last_step = !big_q || ((sx_q == 2'd2) && (sy_q == 2'd2));
  end

  always_comb begin
    state_d         = state_q;
    clear_pending_d = clear_pending_q;
    cx_d            = cx_q;
    cy_d            = cy_q;
    colour_d        = colour_q;
    big_d           = big_q;
    sx_d            = sx_q;
    sy_d            = sy_q;
    clr_addr_d      = clr_addr_q;
    last_clear_d    = 1'b0;
    pen_ack_d       = 1'b0;
    clear_done_d    = last_clear_q;
    busy_d          = 1'b0;
    wr_en_d         = 1'b0;
    wr_addr_d       = wr_addr_q;
    wr_data_d       = wr_data_q;

    case (state_q)
      c_idle: begin
        if (clear_pending_q || bus.clear_req) begin
          state_d         = c_clear;
          clear_pending_d = 1'b0;
          clr_addr_d      = '0;
          busy_d          = 1'b1;
        end else if (bus.pen_req) begin
          state_d   = c_stamp;
          pen_ack_d = 1'b1;
          cx_d      = bus.pen_x;
          cy_d      = bus.pen_y;
          colour_d  = bus.pen_colour;
          big_d     = bus.brush_big;
          sx_d      = bus.brush_big ? 2'd0 : 2'd1;
          sy_d      = bus.brush_big ? 2'd0 : 2'd1;
        end
      end

      c_stamp: begin
        busy_d = 1'b1;
        if (bus.clear_req) begin
          clear_pending_d = 1'b1;
        end
        // Clipped points still consume their cycle so stamp length is fixed.
        if (w_in_range) begin
          wr_en_d   = 1'b1;
          wr_addr_d = w_addr;
          wr_data_d = colour_q;
        end
        if (w_last_step) begin
          state_d = c_idle;
        end else if (sx_q == 2'd2) begin
          sx_d = 2'd0;
          sy_d = sy_q + 2'd1;
        end else begin
          sx_d = sx_q + 2'd1;
        end
      end

      c_clear: begin
        busy_d    = 1'b1;
        wr_en_d   = 1'b1;
        wr_addr_d = clr_addr_q;
        wr_data_d = CLEAR_COLOUR;
        if (clr_addr_q == c_last_addr) begin
          state_d      = c_idle;
          last_clear_d = 1'b1;
        end else begin
          clr_addr_d = clr_addr_q + 13'd1;
        end
      end

      default: begin
        state_d = c_idle;
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (reset) begin
      state_q         <= c_idle;
      clear_pending_q <= 1'b0;
      cx_q            <= '0;
      cy_q            <= '0;
      colour_q        <= '0;
      big_q           <= 1'b0;
      sx_q            <= '0;
      sy_q            <= '0;
      clr_addr_q      <= '0;
      last_clear_q    <= 1'b0;
      pen_ack_q       <= 1'b0;
      clear_done_q    <= 1'b0;
      busy_q          <= 1'b0;
      wr_en_q         <= 1'b0;
      wr_addr_q       <= '0;
      wr_data_q       <= '0;
    end else begin
      state_q         <= state_d;
      clear_pending_q <= clear_pending_d;
      cx_q            <= cx_d;
      cy_q            <= cy_d;
      colour_q        <= colour_d;
      big_q           <= big_d;
      sx_q            <= sx_d;
      sy_q            <= sy_d;
      clr_addr_q      <= clr_addr_d;
      last_clear_q    <= last_clear_d;
      pen_ack_q       <= pen_ack_d;
      clear_done_q    <= clear_done_d;
      busy_q          <= busy_d;
      wr_en_q         <= wr_en_d;
      wr_addr_q       <= wr_addr_d;
      wr_data_q       <= wr_data_d;
    end
  end

  assign bus.pen_ack    = pen_ack_q;
  assign bus.clear_done = clear_done_q;
  assign bus.busy       = busy_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_canvas_write_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_canvas_write_sequencer                                            |
// | Directed stimulus with a cycle-stamped scoreboard on the outputs.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_canvas_write_sequencer;

  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  wr_t  wr_q[$];
  int   ack_q[$];
  int   done_q[$];
  wr_t  mon_e;
  int   mon_c;

  canvas_write_sequencer_if bus ();

  canvas_write_sequencer #(
    .WIDTH        (96),
    .HEIGHT       (64),
    .CLEAR_COLOUR (16'h0000)
  ) dut (
    .CLOCK (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every observed write/ack/done must match the next expected event, cycle included.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      total++;
      if (wr_q.size() == 0) begin
        bad++;
        $display("FAIL write: unexpected write addr=%0d data=%h at cycle %0d, want none",
                 bus.wr_addr, bus.wr_data, cyc);
      end else begin
        mon_e = wr_q.pop_front();
        if (mon_e.cyc != cyc || mon_e.addr != int'(bus.wr_addr) || mon_e.data != int'(bus.wr_data)) begin
          bad++;
          $display("FAIL write: got cycle=%0d addr=%0d data=%h, want cycle=%0d addr=%0d data=%h",
                   cyc, bus.wr_addr, bus.wr_data, mon_e.cyc, mon_e.addr, mon_e.data[15:0]);
        end
      end
    end
    if (bus.pen_ack === 1'b1) begin
      total++;
      if (ack_q.size() == 0) begin
        bad++;
        $display("FAIL pen_ack: unexpected ack at cycle %0d, want none", cyc);
      end else begin
        mon_c = ack_q.pop_front();
        if (mon_c != cyc) begin
          bad++;
          $display("FAIL pen_ack: got cycle %0d, want cycle %0d", cyc, mon_c);
        end
      end
    end
    if (bus.clear_done === 1'b1) begin
      total++;
      if (done_q.size() == 0) begin
        bad++;
        $display("FAIL clear_done: unexpected pulse at cycle %0d, want none", cyc);
      end else begin
        mon_c = done_q.pop_front();
        if (mon_c != cyc) begin
          bad++;
          $display("FAIL clear_done: got cycle %0d, want cycle %0d", cyc, mon_c);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic exp_wr(input int c, input int a, input int d);
    wr_q.push_back('{c, a, d});
  endtask

  task automatic start_pen(input int x, input int y, input int col, input bit big);
    bus.pen_x      = 7'(x);
    bus.pen_y      = 6'(y);
    bus.pen_colour = 16'(col);
    bus.brush_big  = big;
    bus.pen_req    = 1'b1;
  endtask

  task automatic wait_ack(input int limit);
    int n = 0;
    while (bus.pen_ack !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus.pen_ack !== 1'b1) begin
      bad++;
      $display("FAIL ack_wait: pen_ack not seen within %0d cycles, want ack", limit);
    end
    bus.pen_req = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: still running at cycle %0d, want finish", cyc);
    $fatal(1);
  end

  initial begin
    int c;
    int a;
    int hi;
    int got;
    int t5_addr[9];
    t5_addr = '{873, 874, 875, 969, 970, 971, 1065, 1066, 1067};

    bus.pen_req    = 1'b0;
    bus.pen_x      = '0;
    bus.pen_y      = '0;
    bus.pen_colour = '0;
    bus.brush_big  = 1'b0;
    bus.clear_req  = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_wr_en",      int'(bus.wr_en),      0);
    chk("rst_wr_addr",    int'(bus.wr_addr),    0);
    chk("rst_wr_data",    int'(bus.wr_data),    0);
    chk("rst_busy",       int'(bus.busy),       0);
    chk("rst_pen_ack",    int'(bus.pen_ack),    0);
    chk("rst_clear_done", int'(bus.clear_done), 0);
    rst = 1'b0;

    // 1x1 stamp at (10,5)
    @(negedge clk);
    c = cyc;
    start_pen(10, 5, 'hF800, 1'b0);
    ack_q.push_back(c + 1);
    exp_wr(c + 2, 490, 'hF800);
    wait_ack(10);
    @(negedge clk);
    chk("t1_busy_cycle1", int'(bus.busy), 1);
    @(negedge clk);
    chk("t1_busy_cycle2",  int'(bus.busy),  0);
    chk("t1_wr_en_cycle2", int'(bus.wr_en), 0);

    // 3x3 stamp at the top-left corner
    @(negedge clk);
    c = cyc;
    a = c + 1;
    start_pen(0, 0, 'h07E0, 1'b1);
    ack_q.push_back(a);
    exp_wr(a + 5, 0,  'h07E0);
    exp_wr(a + 6, 1,  'h07E0);
    exp_wr(a + 8, 96, 'h07E0);
    exp_wr(a + 9, 97, 'h07E0);
    wait_ack(10);
    hi = 0;
    repeat (9) begin
      @(negedge clk);
      if (bus.busy === 1'b1) hi++;
    end
    chk("t2_busy_cycles", hi, 9);
    @(negedge clk);
    chk("t2_busy_after", int'(bus.busy), 0);

    // 3x3 stamp at the bottom-right corner
    @(negedge clk);
    c = cyc;
    a = c + 1;
    start_pen(95, 63, 'h001F, 1'b1);
    ack_q.push_back(a);
    exp_wr(a + 1, 6046, 'h001F);
    exp_wr(a + 2, 6047, 'h001F);
    exp_wr(a + 4, 6142, 'h001F);
    exp_wr(a + 5, 6143, 'h001F);
    wait_ack(10);
    hi = 0;
    repeat (9) begin
      @(negedge clk);
      if (bus.busy === 1'b1) hi++;
    end
    chk("t3_busy_cycles", hi, 9);
    @(negedge clk);
    chk("t3_busy_after", int'(bus.busy), 0);

    // Simultaneous clear and pen request: clear wins, pen waits
    @(negedge clk);
    c = cyc;
    start_pen(2, 0, 'h1234, 1'b0);
    bus.clear_req = 1'b1;
    for (int k = 0; k < 6144; k++) exp_wr(c + 2 + k, k, 'h0000);
    done_q.push_back(c + 6146);
    ack_q.push_back(c + 6146);
    exp_wr(c + 6147, 2, 'h1234);
    @(negedge clk);
    bus.clear_req = 1'b0;
    chk("t4_busy_in_clear", int'(bus.busy), 1);
    wait_ack(7000);
    repeat (3) @(negedge clk);

    // Clear requested mid-stamp; extra clear pulses during the clear are ignored
    @(negedge clk);
    c = cyc;
    a = c + 1;
    start_pen(10, 10, 'hABCD, 1'b1);
    ack_q.push_back(a);
    for (int k = 0; k < 9; k++) exp_wr(a + 1 + k, t5_addr[k], 'hABCD);
    for (int k = 0; k < 6144; k++) exp_wr(a + 11 + k, k, 'h0000);
    done_q.push_back(a + 6155);
    ack_q.push_back(a + 6155);
    exp_wr(a + 6156, 5, 'h00FF);
    wait_ack(10);
    repeat (3) @(negedge clk);
    bus.clear_req = 1'b1;
    start_pen(5, 0, 'h00FF, 1'b0);
    got = 0;
    for (int i = 0; i < 7000 && got == 0; i++) begin
      @(negedge clk);
      bus.clear_req = ((cyc - a) == 100) || ((cyc - a) == 3000);
      if (bus.pen_ack === 1'b1) begin
        got = 1;
        bus.pen_req = 1'b0;
      end
    end
    chk("t5_ack_seen", got, 1);
    repeat (3) @(negedge clk);

    // Reset while the clear is writing address 1000
    @(negedge clk);
    c = cyc;
    bus.clear_req = 1'b1;
    for (int k = 0; k <= 1000; k++) exp_wr(c + 2 + k, k, 'h0000);
    @(negedge clk);
    bus.clear_req = 1'b0;
    while (cyc < c + 1002) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_wr_en",      int'(bus.wr_en),      0);
    chk("t6_wr_addr",    int'(bus.wr_addr),    0);
    chk("t6_busy",       int'(bus.busy),       0);
    chk("t6_clear_done", int'(bus.clear_done), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    c = cyc;
    start_pen(1, 1, 'h0F0F, 1'b0);
    ack_q.push_back(c + 1);
    exp_wr(c + 2, 97, 'h0F0F);
    wait_ack(10);
    repeat (4) @(negedge clk);

    chk("left_writes", wr_q.size(),   0);
    chk("left_acks",   ack_q.size(),  0);
    chk("left_dones",  done_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/canvas_write_sequencer.md
Name: canvas_write_sequencer

Overview:
- Owns the single write port of the 96x64, 16-bit RGB565 drawing-board memory whose read port feeds the OLED colour/menu overlay as curr_pixel_oled.
- Shares that write port between two requesters: the pen (cursor paint, 1x1 or 3x3 stamp, in the colour chosen from the palette menu) and a full-canvas clear engine.
- Sequences every multi-pixel operation one write per cycle, clipping at canvas edges.
- The display read path is independent and is not touched.

Parameters:
- WIDTH, 96, canvas width in pixels.
- HEIGHT, 64, canvas height in pixels.
- CLEAR_COLOUR, 16'h0000, RGB565 value written by a clear.

Ports:
- CLOCK  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- pen_req  in  1  level; request one stamp at pen_x/pen_y.
- pen_x  in  7  stamp centre column.
- pen_y  in  6  stamp centre row.
- pen_colour  in  16  RGB565 stamp colour (the menu's selected_colour).
- brush_big  in  1  0 = 1x1 stamp, 1 = 3x3 stamp.
- pen_ack  out  1  one-cycle pulse: request accepted, inputs latched.
- clear_req  in  1  single-cycle pulse: request a canvas clear.
- clear_done  out  1  one-cycle pulse after the final clear write.
- busy  out  1  high while a stamp or clear is in progress.
- wr_en  out  1  canvas write strobe.
- wr_addr  out  13  canvas address, y*WIDTH+x.
- wr_data  out  16  canvas write data.

Behaviour:
- Reset (synchronous; also when asserted mid-operation):
  - State returns to IDLE.
  - All outputs go 0 on the next edge, including wr_addr and wr_data.
  - clear_pending is cleared.
  - No clear_done is issued for an aborted clear.
- All outputs are registered.
- States: IDLE, STAMP, CLEAR.
- clear_pending flag:
  - Set by clear_req in IDLE or STAMP.
  - clear_req during CLEAR is ignored.
  - Cleared when CLEAR is entered.
- IDLE priority: clear_pending (or clear_req this cycle) beats pen_req.
  - Simultaneous clear_req and pen_req: enter CLEAR; pen_req is not acked.
  - pen_req still high when IDLE is re-entered is accepted then.
- Pen accept, cycle 0:
  - pen_ack=1 for one cycle.
  - pen_x, pen_y, pen_colour and brush_big are latched.
  - Go to STAMP.
- Requester must drop pen_req after pen_ack. A held pen_req is re-accepted as a new stamp, which is harmless.
- STAMP, 1x1:
  - One cycle: cycle 1 drives wr_en, wr_addr=y*WIDTH+x, wr_data=colour.
- STAMP, 3x3:
  - Exactly 9 cycles, always, in raster order: dy=-1..+1 outer, dx=-1..+1 inner.
  - Offset math uses 8-bit signed arithmetic.
  - A point with x<0, x>=WIDTH, y<0 or y>=HEIGHT is clipped: wr_en=0 that cycle, but the cycle is still consumed.
  - Out-of-range centres follow the same clipping rule, so a 1x1 stamp at x>=WIDTH is acked but writes nothing.
- busy timing:
  - High from cycle 1 through the last stamp cycle.
  - Next request can be accepted in the first cycle busy=0, i.e. back-to-back stamps cost N+1 cycles.
- CLEAR:
  - wr_en=1, wr_data=CLEAR_COLOUR, wr_addr=0..WIDTH*HEIGHT-1 (0..6143), one address per cycle.
  - First write in the cycle after entry.
  - busy=1 throughout.
  - clear_done=1 in the cycle after the write to address 6143, together with busy=0 and the return to IDLE.
- pen_req during STAMP or CLEAR is never acked; it waits.
- wr_en is 0 in IDLE; wr_addr and wr_data hold their last value.

Test Plan:
- Reset then 1x1 stamp: pen_req, pen_x=10, pen_y=5, colour=16'hF800, brush_big=0.
  - Response: pen_ack at cycle 0; cycle 1 wr_en=1, wr_addr=490, wr_data=F800; cycle 2 busy=0, wr_en=0.
- 3x3 stamp at (0,0), colour 16'h07E0:
  - 9 busy cycles.
  - wr_en high only in cycles 5, 6, 8, 9, with addresses 0, 1, 96, 97.
- 3x3 stamp at (95,63):
  - wr_en high only in cycles 1, 2, 4, 5, with addresses 6046, 6047, 6142, 6143.
  - No address above 6143 ever appears.
- clear_req and pen_req in the same IDLE cycle:
  - No pen_ack; 6144 writes of 16'h0000 to addresses 0..6143.
  - clear_done pulses one cycle after the last write.
  - pen_ack is issued in that same IDLE cycle.
- clear_req pulse during cycle 3 of a 3x3 stamp:
  - Stamp completes all 9 cycles.
  - CLEAR is then entered ahead of a waiting pen_req.
  - clear_req pulses during CLEAR do not cause a second clear.
- reset asserted at clear write to address 1000:
  - wr_en=0 on the next edge and IDLE entered.
  - clear_done never pulses.
  - A following 1x1 stamp at (1,1) writes address 97.
